// File: rtl/rv32i_lsu.sv
// Load/store unit for the multi-cycle rv32i core: aligns stores, extends loads,
// and drives a variable-latency valid/ready data-memory port with timeout.
module rv32i_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_store_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  resp_valid_o,
    output logic [31:0]           resp_rdata_o,
    output logic                  resp_misaligned_o,
    output logic                  resp_timeout_o,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_wmask_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] TO_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic                 TO_EN    = (TIMEOUT_CYCLES > 0);

    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (lo[0] == 1'b0);
            2'b10:   ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] base_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lo,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {lo, 3'b000};
        case (size)
            2'b00:   r = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   r = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [1:0]            lo_q, lo_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic                  mem_valid_q, mem_valid_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]            mem_wmask_q, mem_wmask_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic                  resp_mis_q, resp_mis_d;
    logic                  resp_to_q, resp_to_d;
    logic [CNT_WIDTH-1:0]  cnt_inc_s;
    logic                  to_hit_s;

    assign cnt_inc_s = cnt_q + CNT_WIDTH'(1'b1);
    // mem_ready in the limit cycle takes priority because it is checked first below.
    assign to_hit_s  = TO_EN && (cnt_inc_s == TO_LIMIT);

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lo_d         = lo_q;
        size_d       = size_q;
        uns_d        = uns_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wmask_d  = mem_wmask_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_mis_d   = 1'b0;
        resp_to_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    lo_d   = req_addr_i[1:0];
                    size_d = req_size_i;
                    uns_d  = req_unsigned_i;
                    cnt_d  = {CNT_WIDTH{1'b0}};
                    if (is_legal(req_size_i, req_addr_i[1:0])) begin
                        state_d     = S_MEM;
                        mem_valid_d = 1'b1;
                        mem_we_d    = req_store_i;
                        mem_addr_d  = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        mem_wmask_d = req_store_i ? (base_mask(req_size_i) << req_addr_i[1:0]) : 4'b0000;
                        mem_wdata_d = req_store_i ? (req_wdata_i << {req_addr_i[1:0], 3'b000}) : 32'h0000_0000;
                    end else begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_mis_d   = 1'b1;
                        resp_rdata_d = 32'h0000_0000;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MEM: begin
                if (mem_ready_i) begin
                    state_d      = S_RESP;
                    mem_valid_d  = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_we_q ? 32'h0000_0000 : extend_load(mem_rdata_i, lo_q, size_q, uns_q);
                    cnt_d        = {CNT_WIDTH{1'b0}};
                end else if (to_hit_s) begin
                    state_d      = S_RESP;
                    mem_valid_d  = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_to_d    = 1'b1;
                    resp_rdata_d = 32'h0000_0000;
                    cnt_d        = {CNT_WIDTH{1'b0}};
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_WIDTH{1'b0}};
            end
            default: begin
                state_d     = S_IDLE;
                cnt_d       = {CNT_WIDTH{1'b0}};
                mem_valid_d = 1'b0;
                mem_we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight access.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CNT_WIDTH{1'b0}};
            lo_q         <= 2'b00;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_WIDTH{1'b0}};
            mem_wmask_q  <= 4'b0000;
            mem_wdata_q  <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_mis_q   <= 1'b0;
            resp_to_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lo_q         <= lo_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wmask_q  <= mem_wmask_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
            resp_to_q    <= resp_to_d;
        end
    end

    assign req_ready_o       = (state_q == S_IDLE);
    assign resp_valid_o      = resp_valid_q;
    assign resp_rdata_o      = resp_rdata_q;
    assign resp_misaligned_o = resp_mis_q;
    assign resp_timeout_o    = resp_to_q;
    assign mem_valid_o       = mem_valid_q;
    assign mem_we_o          = mem_we_q;
    assign mem_addr_o        = mem_addr_q;
    assign mem_wmask_o       = mem_wmask_q;
    assign mem_wdata_o       = mem_wdata_q;

endmodule
